// File: rtl/stream_mux_nx1_pkg.sv
// stream_mux_pkg: shared types, mode constants and helpers for stream_mux_nx1.
package stream_mux_pkg;
  typedef enum logic {IDLE, LOCKED} state_t;
  localparam int MODE_RR = 0;
  localparam int MODE_FIXED = 1;
  localparam int MODE_SEL = 2;
  // A 2-input mux still needs a 1-bit channel index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/stream_mux_nx1_if.sv
// stream_mux_nx1_if: N producer channels in, one consumer stream out, plus external select.
interface stream_mux_nx1_if #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH = 8,
  parameter int CHAN_W = stream_mux_pkg::clog2_min1(NUM_INPUTS)
);
  logic [NUM_INPUTS-1:0] in_valid;
  logic [NUM_INPUTS*WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0] in_last;
  logic [NUM_INPUTS-1:0] in_ready;
  logic [CHAN_W-1:0] sel;
  logic out_valid;
  logic [WIDTH-1:0] out_data;
  logic out_last;
  logic [CHAN_W-1:0] out_chan;
  logic out_ready;
  modport master (
    output in_valid, in_data, in_last, sel, out_ready,
    input in_ready, out_valid, out_data, out_last, out_chan
  );
  modport slave (
    input in_valid, in_data, in_last, sel, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chan
  );
endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// rr_arbiter: first requester at or above ptr_i (with wrap) wins; ptr_i=0 gives fixed priority.
module rr_arbiter import stream_mux_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  localparam int CHAN_W = clog2_min1(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [CHAN_W-1:0]     ptr_i,
  output logic [NUM_INPUTS-1:0] gnt_o,
  output logic [CHAN_W-1:0]     idx_o,
  output logic                  valid_o
);
  localparam logic [NUM_INPUTS-1:0] ONE = NUM_INPUTS'(1);
  logic [NUM_INPUTS-1:0] rot;
  always_comb begin
    rot = NUM_INPUTS'({req_i, req_i} >> ptr_i);
    idx_o = '0;
    valid_o = 1'b0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--)
      if (rot[k]) begin
        valid_o = 1'b1;
        idx_o = CHAN_W'((int'(ptr_i) + k) % NUM_INPUTS);
      end
  end
  assign gnt_o = valid_o ? ONE << idx_o : '0;
endmodule

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N:1 packet-aware stream mux with a registered single-entry output stage.
module stream_mux_nx1 import stream_mux_pkg::*; #(
  parameter int NUM_INPUTS = 4,
  parameter int WIDTH = 8,
  parameter int MODE = MODE_RR
) (
  input logic clk,
  input logic rst_n,
  stream_mux_nx1_if.slave bus
);
  localparam int CHAN_W = clog2_min1(NUM_INPUTS);
  localparam int PAD_N = 2 ** CHAN_W;
  localparam logic [NUM_INPUTS-1:0] ONE = NUM_INPUTS'(1);
  state_t state_q, state_d;
  logic [CHAN_W-1:0] lock_chan_q, lock_chan_d, rr_ptr_q, rr_ptr_d;
  logic [CHAN_W-1:0] arb_ptr, arb_idx, grant;
  logic [NUM_INPUTS-1:0] arb_gnt, gnt_vec, ready;
  logic [PAD_N-1:0] valid_pad;
  logic arb_valid, sel_hit, can_load, xfer, xfer_last, locked;
  logic [WIDTH-1:0] xfer_data;
  logic out_valid_q, out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [CHAN_W-1:0] out_chan_q;
  assign arb_ptr = (MODE == MODE_RR) ? rr_ptr_q : '0;
  rr_arbiter #(.NUM_INPUTS(NUM_INPUTS)) u_arb (
    .req_i(bus.in_valid),
    .ptr_i(arb_ptr),
    .gnt_o(arb_gnt),
    .idx_o(arb_idx),
    .valid_o(arb_valid)
  );
  // Padding lets an out-of-range sel be indexed safely; the range check rejects it.
  assign valid_pad = PAD_N'(bus.in_valid);
  assign sel_hit = (int'(bus.sel) < NUM_INPUTS) && valid_pad[bus.sel];
  assign locked = (state_q == LOCKED);
  assign grant = locked ? lock_chan_q : (MODE == MODE_SEL) ? bus.sel : arb_idx;
  assign gnt_vec = locked ? ONE << lock_chan_q
                 : (MODE == MODE_SEL) ? (sel_hit ? ONE << bus.sel : '0)
                 : arb_gnt;
  assign can_load = !out_valid_q || bus.out_ready;
  assign ready = (rst_n && can_load) ? gnt_vec : '0;
  assign xfer = |(bus.in_valid & ready);
  always_comb begin
    xfer_data = '0;
    xfer_last = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++)
      if (grant == CHAN_W'(i)) begin
        xfer_data = bus.in_data[i*WIDTH +: WIDTH];
        xfer_last = bus.in_last[i];
      end
  end
  always_comb begin
    state_d = state_q;
    lock_chan_d = lock_chan_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      state_d = xfer_last ? IDLE : LOCKED;
      lock_chan_d = grant;
      rr_ptr_d = (MODE != MODE_RR || !xfer_last) ? rr_ptr_q
               : (int'(grant) == NUM_INPUTS - 1) ? '0 : grant + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      lock_chan_q <= '0;
      rr_ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_chan_q <= '0;
    end else begin
      state_q <= state_d;
      lock_chan_q <= lock_chan_d;
      rr_ptr_q <= rr_ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_data_q <= xfer_data;
        out_last_q <= xfer_last;
        out_chan_q <= grant;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  assign bus.in_ready = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data = out_data_q;
  assign bus.out_last = out_last_q;
  assign bus.out_chan = out_chan_q;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// tb_stream_mux_nx1: directed checks of round-robin, fixed-priority and select modes.
module tb_stream_mux_nx1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  stream_mux_nx1_if #(.NUM_INPUTS(4), .WIDTH(8)) b0 ();
  stream_mux_nx1_if #(.NUM_INPUTS(4), .WIDTH(8)) b1 ();
  stream_mux_nx1_if #(.NUM_INPUTS(5), .WIDTH(8)) b2 ();
  stream_mux_nx1 #(.NUM_INPUTS(4), .WIDTH(8), .MODE(0)) u_rr (.clk(clk), .rst_n(rst_n), .bus(b0));
  stream_mux_nx1 #(.NUM_INPUTS(4), .WIDTH(8), .MODE(1)) u_fp (.clk(clk), .rst_n(rst_n), .bus(b1));
  stream_mux_nx1 #(.NUM_INPUTS(5), .WIDTH(8), .MODE(2)) u_sel (.clk(clk), .rst_n(rst_n), .bus(b2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    b0.in_valid = '1; b0.in_last = '1; b0.sel = '0; b0.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) b0.in_data[i*8 +: 8] = 8'(8'h10 + i);
    b1.in_valid = '0; b1.in_last = '1; b1.in_data = '0; b1.sel = '0; b1.out_ready = 1'b1;
    b2.in_valid = '0; b2.in_last = '1; b2.in_data = '0; b2.sel = '0; b2.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 32'(b0.out_valid), 0);
    chk("rst_in_ready", 32'(b0.in_ready), 0);
    chk("rst_out_data", 32'(b0.out_data), 0);
    rst_n = 1'b1;
    #1;
    chk("first_ready", 32'(b0.in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_valid", 32'(b0.out_valid), 1);
      chk("rr_chan", 32'(b0.out_chan), 32'(k % 4));
      chk("rr_data", 32'(b0.out_data), 32'('h10 + k % 4));
    end
    b0.in_valid = 4'b0111; b0.in_last = 4'b1011; b0.in_data[16 +: 8] = 8'hA0;
    #1;
    chk("lock_ready0", 32'(b0.in_ready), 4);
    tick();
    chk("lock_a0_data", 32'(b0.out_data), 'hA0);
    chk("lock_a0_chan", 32'(b0.out_chan), 2);
    chk("lock_a0_last", 32'(b0.out_last), 0);
    b0.in_data[16 +: 8] = 8'hA1;
    #1;
    chk("lock_ready1", 32'(b0.in_ready), 4);
    tick();
    chk("lock_a1_data", 32'(b0.out_data), 'hA1);
    chk("lock_a1_chan", 32'(b0.out_chan), 2);
    b0.in_data[16 +: 8] = 8'hA2; b0.in_last = 4'b1111;
    tick();
    chk("lock_a2_data", 32'(b0.out_data), 'hA2);
    chk("lock_a2_last", 32'(b0.out_last), 1);
    chk("next_wrap_ch0", 32'(b0.in_ready), 1);
    b0.in_valid = 4'b1111; b0.in_data[16 +: 8] = 8'h12;
    #1;
    chk("next_ch3", 32'(b0.in_ready), 8);
    tick();
    chk("bp_first_chan", 32'(b0.out_chan), 3);
    b0.out_ready = 1'b0;
    #1;
    chk("bp_ready_off", 32'(b0.in_ready), 0);
    repeat (5) begin
      tick();
      chk("bp_hold_data", 32'(b0.out_data), 'h13);
      chk("bp_hold_chan", 32'(b0.out_chan), 3);
      chk("bp_hold_valid", 32'(b0.out_valid), 1);
      chk("bp_hold_ready", 32'(b0.in_ready), 0);
    end
    b0.out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(b0.in_ready), 1);
    tick();
    chk("bp_resume_ch0", 32'(b0.out_data), 'h10);
    tick();
    chk("bp_resume_ch1", 32'(b0.out_data), 'h11);
    b0.in_valid = '0;
    tick();
    chk("drain_valid", 32'(b0.out_valid), 0);
    b1.in_valid = 4'b1010; b1.in_data = 32'h2300_2100;
    #1;
    chk("fp_ready", 32'(b1.in_ready), 2);
    repeat (4) begin
      tick();
      chk("fp_chan", 32'(b1.out_chan), 1);
      chk("fp_data", 32'(b1.out_data), 'h21);
      chk("fp_starve", 32'(b1.in_ready), 2);
    end
    b1.in_valid = '0;
    b2.in_valid = 5'b01000; b2.in_data[24 +: 8] = 8'h33; b2.sel = 3'd3;
    #1;
    chk("sel3_ready", 32'(b2.in_ready), 8);
    tick();
    chk("sel3_chan", 32'(b2.out_chan), 3);
    chk("sel3_data", 32'(b2.out_data), 'h33);
    b2.in_valid = 5'b11111; b2.sel = 3'd5;
    #1;
    chk("sel5_ready", 32'(b2.in_ready), 0);
    b2.sel = 3'd7;
    #1;
    chk("sel7_ready", 32'(b2.in_ready), 0);
    tick();
    chk("sel_oob_idle", 32'(b2.out_valid), 0);
    b2.sel = 3'd1; b2.in_last = 5'b11101; b2.in_data[8 +: 8] = 8'hB0;
    #1;
    chk("sel1_ready", 32'(b2.in_ready), 2);
    tick();
    chk("sel_b0_data", 32'(b2.out_data), 'hB0);
    chk("sel_b0_last", 32'(b2.out_last), 0);
    b2.sel = 3'd4; b2.in_valid = 5'b11101;
    #1;
    chk("sel_lock_ignore", 32'(b2.in_ready), 2);
    tick();
    chk("sel_lock_gap", 32'(b2.out_valid), 0);
    b2.in_valid = 5'b11111; b2.in_last = '1; b2.in_data[8 +: 8] = 8'hB1;
    #1;
    chk("sel_lock_ready", 32'(b2.in_ready), 2);
    tick();
    chk("sel_b1_data", 32'(b2.out_data), 'hB1);
    chk("sel_b1_chan", 32'(b2.out_chan), 1);
    chk("sel_b1_last", 32'(b2.out_last), 1);
    chk("sel_unlock", 32'(b2.in_ready), 16);
    tick();
    chk("sel4_chan", 32'(b2.out_chan), 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
